dog_ctrl: RTL and testbench

- Sequences the hunting-dog sprite for each round. Runs the intro walk, sniff, jump and dive into the grass, then the post-round pop-up that shows ducks held or laughs.
- Drives position, sprite-frame and layering to the dog renderer. Exchanges start/result handshakes with the game FSM.
- All motion advances once per video frame, derived from frame_clk.

---
 rtl/dog_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dog_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dog_ctrl.sv
// Hunting-dog sprite sequencer: intro walk, sniff, jump and dive, then the
// post-round pop-up. All motion advances once per synchronized frame_clk rise.
module dog_ctrl #(
    parameter logic [9:0] START_X      = 10'd0,
    parameter logic [9:0] WALK_END_X   = 10'd240,
    parameter logic [9:0] WALK_STEP    = 10'd2,
    parameter logic [9:0] GROUND_Y     = 10'd360,
    parameter logic [9:0] HIDE_Y       = 10'd400,
    parameter logic [9:0] SHOW_X       = 10'd288,
    parameter logic [9:0] SHOW_Y       = 10'd330,
    parameter logic [9:0] RISE_STEP    = 10'd2,
    parameter logic [7:0] SNIFF_FRAMES = 8'd60,
    parameter logic [7:0] SHOW_FRAMES  = 8'd90,
    parameter logic [3:0] JUMP_V       = 4'd6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       round_start,
    input  logic       result_valid,
    input  logic [1:0] result_code,
    output logic [9:0] dog_x,
    output logic [9:0] dog_y,
    output logic [2:0] dog_frame,
    output logic       dog_visible,
    output logic       dog_front,
    output logic       busy,
    output logic       intro_done,
    output logic       show_done
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_WALK   = 4'd1;
    localparam logic [3:0] S_SNIFF  = 4'd2;
    localparam logic [3:0] S_JUMP   = 4'd3;
    localparam logic [3:0] S_FALL   = 4'd4;
    localparam logic [3:0] S_HIDDEN = 4'd5;
    localparam logic [3:0] S_RISE   = 4'd6;
    localparam logic [3:0] S_SHOW   = 4'd7;
    localparam logic [3:0] S_SINK   = 4'd8;

    logic [3:0] state;
    logic       fclk_p0, fclk_p1, fclk_p2;
    logic       tick;
    logic [7:0] cnt;
    logic [3:0] vy;
    logic [2:0] walk_cnt;
    logic [9:0] next_x, fall_y, rise_y, sink_y;
    logic [3:0] vy_inc;

    function automatic logic [2:0] result_frame(input logic [1:0] code);
        case (code)
            2'd0:    return 3'd5;
            2'd1:    return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    // p0/p1 synchronize the foreign frame clock, p2 holds its previous value
    assign tick   = fclk_p1 & ~fclk_p2;
    assign next_x = dog_x + WALK_STEP;
    assign vy_inc = vy + 4'd1;
    assign fall_y = dog_y + {6'd0, vy_inc};
    assign rise_y = dog_y - RISE_STEP;
    assign sink_y = dog_y + RISE_STEP;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            fclk_p0     <= 1'b0;
            fclk_p1     <= 1'b0;
            fclk_p2     <= 1'b0;
            dog_x       <= START_X;
            dog_y       <= GROUND_Y;
            dog_frame   <= 3'd0;
            dog_visible <= 1'b0;
            dog_front   <= 1'b1;
            busy        <= 1'b0;
            intro_done  <= 1'b0;
            show_done   <= 1'b0;
            cnt         <= 8'd0;
            vy          <= 4'd0;
            walk_cnt    <= 3'd0;
        end else begin
            fclk_p0    <= frame_clk;
            fclk_p1    <= fclk_p0;
            fclk_p2    <= fclk_p1;
            intro_done <= 1'b0;
            show_done  <= 1'b0;
            // round_start outranks result_valid when both land in HIDDEN
            if (round_start && (state == S_IDLE || state == S_HIDDEN)) begin
                state       <= S_WALK;
                dog_x       <= START_X;
                dog_y       <= GROUND_Y;
                dog_frame   <= 3'd0;
                dog_visible <= 1'b1;
                dog_front   <= 1'b1;
                busy        <= 1'b1;
                walk_cnt    <= 3'd0;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_HIDDEN: if (result_valid) begin
                        state       <= S_RISE;
                        dog_x       <= SHOW_X;
                        dog_y       <= HIDE_Y;
                        dog_frame   <= result_frame(result_code);
                        dog_visible <= 1'b1;
                        dog_front   <= 1'b0;
                        busy        <= 1'b1;
                    end
                    S_WALK: if (tick) begin
                        if (next_x >= WALK_END_X) begin
                            dog_x     <= WALK_END_X;
                            dog_frame <= 3'd2;
                            cnt       <= 8'd0;
                            state     <= S_SNIFF;
                        end else begin
                            dog_x    <= next_x;
                            walk_cnt <= walk_cnt + 3'd1;
                            if (walk_cnt == 3'd7)
                                dog_frame <= {2'b00, ~dog_frame[0]};
                        end
                    end
                    S_SNIFF: if (tick) begin
                        if ((cnt + 8'd1) == SNIFF_FRAMES) begin
                            vy        <= JUMP_V;
                            dog_frame <= 3'd3;
                            state     <= S_JUMP;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    S_JUMP: if (tick) begin
                        dog_y <= dog_y - {6'd0, vy};
                        if (vy == 4'd1) begin
                            vy        <= 4'd0;
                            dog_front <= 1'b0;
                            dog_frame <= 3'd4;
                            state     <= S_FALL;
                        end else begin
                            vy <= vy - 4'd1;
                        end
                    end
                    S_FALL: if (tick) begin
                        vy <= vy_inc;
                        if (fall_y >= HIDE_Y) begin
                            dog_y       <= HIDE_Y;
                            dog_visible <= 1'b0;
                            busy        <= 1'b0;
                            intro_done  <= 1'b1;
                            state       <= S_HIDDEN;
                        end else begin
                            dog_y <= fall_y;
                        end
                    end
                    S_RISE: if (tick) begin
                        if (rise_y <= SHOW_Y) begin
                            dog_y <= SHOW_Y;
                            cnt   <= 8'd0;
                            state <= S_SHOW;
                        end else begin
                            dog_y <= rise_y;
                        end
                    end
                    S_SHOW: if (tick) begin
                        if ((cnt + 8'd1) == SHOW_FRAMES)
                            state <= S_SINK;
                        else
                            cnt <= cnt + 8'd1;
                    end
                    S_SINK: if (tick) begin
                        if (sink_y >= HIDE_Y) begin
                            dog_y       <= HIDE_Y;
                            dog_visible <= 1'b0;
                            busy        <= 1'b0;
                            show_done   <= 1'b1;
                            state       <= S_HIDDEN;
                        end else begin
                            dog_y <= sink_y;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dog_ctrl.sv
// Randomized bench for dog_ctrl: expected sprite trajectories are built per
// round from the motion rules and compared after every frame tick.
module tb_dog_ctrl;

    localparam int START_X = 0, WALK_END_X = 240, WALK_STEP = 2, GROUND_Y = 360;
    localparam int HIDE_Y = 400, SHOW_X = 288, SHOW_Y = 330, RISE_STEP = 2;
    localparam int SNIFF_FRAMES = 60, SHOW_FRAMES = 90, JUMP_V = 6;

    logic       Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0;
    logic       round_start = 1'b0, result_valid = 1'b0;
    logic [1:0] result_code = 2'd0;
    logic [9:0] dog_x, dog_y;
    logic [2:0] dog_frame;
    logic       dog_visible, dog_front, busy, intro_done, show_done;

    dog_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .round_start(round_start), .result_valid(result_valid), .result_code(result_code),
        .dog_x(dog_x), .dog_y(dog_y), .dog_frame(dog_frame), .dog_visible(dog_visible),
        .dog_front(dog_front), .busy(busy), .intro_done(intro_done), .show_done(show_done)
    );

    always #10 Clk = ~Clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] fr;
        logic       vis;
        logic       front;
        logic       busy;
    } snap_t;

    snap_t exp_q[$];
    snap_t cur;
    int    n_checks = 0, n_fail = 0;
    int    intro_seen = 0, show_seen = 0;

    always @(negedge Clk) begin
        if (intro_done) intro_seen++;
        if (show_done) show_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    function automatic snap_t mk(input int x, input int y, input int fr,
                                 input int vis, input int front, input int bsy);
        snap_t s;
        s.x = 10'(x); s.y = 10'(y); s.fr = 3'(fr);
        s.vis = 1'(vis); s.front = 1'(front); s.busy = 1'(bsy);
        return s;
    endfunction

    function automatic snap_t dut_snap();
        return mk(int'(dog_x), int'(dog_y), int'(dog_frame),
                  int'(dog_visible), int'(dog_front), int'(busy));
    endfunction

    function automatic int code_frame(input int code);
        if (code == 0) return 5;
        if (code == 1) return 6;
        return 7;
    endfunction

    // Expected state after each tick of an intro, from walk start to hidden
    task automatic push_intro();
        int x, y;
        for (int n = 1; n < 1000; n++) begin
            x = START_X + n * WALK_STEP;
            if (x >= WALK_END_X) begin
                exp_q.push_back(mk(WALK_END_X, GROUND_Y, 2, 1, 1, 1));
                break;
            end
            exp_q.push_back(mk(x, GROUND_Y, (n / 8) % 2, 1, 1, 1));
        end
        for (int k = 1; k < SNIFF_FRAMES; k++)
            exp_q.push_back(mk(WALK_END_X, GROUND_Y, 2, 1, 1, 1));
        exp_q.push_back(mk(WALK_END_X, GROUND_Y, 3, 1, 1, 1));
        y = GROUND_Y;
        for (int v = JUMP_V; v >= 1; v--) begin
            y -= v;
            exp_q.push_back(mk(WALK_END_X, y, (v == 1) ? 4 : 3, 1, (v == 1) ? 0 : 1, 1));
        end
        for (int v = 1; v < 100; v++) begin
            y += v;
            if (y >= HIDE_Y) begin
                exp_q.push_back(mk(WALK_END_X, HIDE_Y, 4, 0, 0, 0));
                break;
            end
            exp_q.push_back(mk(WALK_END_X, y, 4, 1, 0, 1));
        end
    endtask

    task automatic push_show(input int fr);
        int y;
        for (int n = 1; n < 1000; n++) begin
            y = HIDE_Y - n * RISE_STEP;
            if (y <= SHOW_Y) begin
                exp_q.push_back(mk(SHOW_X, SHOW_Y, fr, 1, 0, 1));
                break;
            end
            exp_q.push_back(mk(SHOW_X, y, fr, 1, 0, 1));
        end
        for (int k = 1; k <= SHOW_FRAMES; k++)
            exp_q.push_back(mk(SHOW_X, SHOW_Y, fr, 1, 0, 1));
        for (int n = 1; n < 1000; n++) begin
            y = SHOW_Y + n * RISE_STEP;
            if (y >= HIDE_Y) begin
                exp_q.push_back(mk(SHOW_X, HIDE_Y, fr, 0, 0, 0));
                break;
            end
            exp_q.push_back(mk(SHOW_X, y, fr, 1, 0, 1));
        end
    endtask

    task automatic frame_pulse();
        @(negedge Clk) frame_clk = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge Clk);
        frame_clk = 1'b0;
        repeat ($urandom_range(4, 9)) @(negedge Clk);
    endtask

    task automatic pulse_in(input int which, input logic [1:0] code);
        round_start  = ((which & 1) != 0);
        result_valid = ((which & 2) != 0);
        result_code  = code;
        @(negedge Clk);
        round_start  = 1'b0;
        result_valid = 1'b0;
    endtask

    task automatic run_traj(input string tag, input int count, input bit inject);
        for (int i = 0; i < count && exp_q.size() > 0; i++) begin
            frame_pulse();
            cur = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, i), 32'(dut_snap()), 32'(cur));
            if (inject && exp_q.size() > 0 && $urandom_range(0, 7) == 0) begin
                pulse_in(int'($urandom_range(1, 3)), 2'($urandom));
                check($sformatf("%s_ignored[%0d]", tag, i), 32'(dut_snap()), 32'(cur));
            end
        end
    endtask

    initial begin
        int i0, s0, code, nshow;
        int codes[4] = '{3, 0, 1, 2};
        snap_t rst_snap;
        rst_snap = mk(START_X, GROUND_Y, 0, 0, 1, 0);

        repeat (3) frame_pulse();
        check("reset_state", 32'(dut_snap()), 32'(rst_snap));
        check("reset_pulses", 32'({intro_done, show_done}), 32'd0);
        @(negedge Clk) Reset = 1'b0;
        repeat (2) frame_pulse();
        pulse_in(2, 2'd3);
        check("idle_hold", 32'(dut_snap()), 32'(rst_snap));

        for (int r = 0; r < 2; r++) begin
            pulse_in(1, 2'd0);
            check("start", 32'(dut_snap()), 32'(mk(START_X, GROUND_Y, 0, 1, 1, 1)));
            i0 = intro_seen;
            push_intro();
            run_traj("intro", 1000, 1'b1);
            check("intro_pulse", 32'(intro_seen - i0), 32'd1);
            nshow = (r == 0) ? 4 : 1;
            for (int k = 0; k < nshow; k++) begin
                code = (r == 0) ? codes[k] : int'($urandom_range(0, 3));
                repeat (2) frame_pulse();
                check("hidden_hold", 32'(dut_snap()), 32'(cur));
                s0 = show_seen;
                pulse_in(2, 2'(code));
                check("show_start", 32'(dut_snap()),
                      32'(mk(SHOW_X, HIDE_Y, code_frame(code), 1, 0, 1)));
                push_show(code_frame(code));
                run_traj("show", 1000, 1'b1);
                check("show_pulse", 32'(show_seen - s0), 32'd1);
            end
        end

        pulse_in(3, 2'd2);
        check("start_wins", 32'(dut_snap()), 32'(mk(START_X, GROUND_Y, 0, 1, 1, 1)));
        push_intro();
        run_traj("walk2", 30, 1'b0);
        repeat (1000) @(negedge Clk);
        check("static_frame", 32'(dut_snap()), 32'(cur));
        frame_pulse();
        check("one_step", 32'(dog_x), 32'(cur.x) + 32'(WALK_STEP));
        cur = exp_q.pop_front();
        run_traj("to_jump", 150 + int'($urandom_range(0, 4)), 1'b0);
        Reset = 1'b1;
        @(negedge Clk);
        check("mid_reset", 32'(dut_snap()), 32'(rst_snap));
        check("mid_reset_pulses", 32'({intro_done, show_done}), 32'd0);
        Reset = 1'b0;
        exp_q.delete();
        pulse_in(1, 2'd0);
        check("restart", 32'(dut_snap()), 32'(mk(START_X, GROUND_Y, 0, 1, 1, 1)));
        push_intro();
        run_traj("restart", 20, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
